// File: rtl/fetch_dual.sv
// Dual-issue instruction fetch front end: PC owner, dual-port imem
// address driver, circular instruction buffer and in-order two-wide
// presentation to decode with flush-on-redirect.
module fetch_dual #(
    parameter logic [31:0]  RESET_PC = 32'h0000_0000,
    parameter int unsigned  DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [31:0]                imem_a1,
    output logic [31:0]                imem_a2,
    input  logic [31:0]                imem_rd1,
    input  logic [31:0]                imem_rd2,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic [1:0]                 dec_ready,
    output logic                       out_valid0,
    output logic [31:0]                out_instr0,
    output logic [31:0]                out_pc0,
    output logic                       out_valid1,
    output logic [31:0]                out_instr1,
    output logic [31:0]                out_pc1,
    output logic [$clog2(DEPTH):0]     buf_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];

    logic [CNT_W-1:0] free_c;
    logic             fetch_c;
    logic [1:0]       dr_sat_c;
    logic [CNT_W-1:0] pop_n_c;
    logic [PTR_W-1:0] rd_ptr1_c;

    // Fetch/pop decision; free space uses only the registered count
    always_comb begin
        free_c   = CNT_W'(DEPTH) - count_q;
        fetch_c  = !redirect_valid && (free_c >= CNT_W'(2));
        dr_sat_c = (dec_ready == 2'd3) ? 2'd2 : dec_ready;
        pop_n_c  = (CNT_W'(dr_sat_c) > count_q) ? count_q : CNT_W'(dr_sat_c);
    end

    // Next-state for PC, pointers and occupancy; redirect flushes everything
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_n_c);
            count_d  = count_q - pop_n_c;
            if (fetch_c) begin
                pc_d     = pc_q + 32'd8;
                wr_ptr_d = wr_ptr_q + PTR_W'(2);
                count_d  = count_q - pop_n_c + CNT_W'(2);
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= {RESET_PC[31:2], 2'b00};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Buffer storage; contents are never observed while their slot is empty
    always_ff @(posedge clk) begin
        if (fetch_c) begin
            instr_mem[wr_ptr_q]             <= imem_rd1;
            pc_mem[wr_ptr_q]                <= pc_q;
            instr_mem[wr_ptr_q + PTR_W'(1)] <= imem_rd2;
            pc_mem[wr_ptr_q + PTR_W'(1)]    <= pc_q + 32'd4;
        end
    end

    // Head presentation to decode and imem addressing
    always_comb begin
        rd_ptr1_c  = rd_ptr_q + PTR_W'(1);
        imem_a1    = pc_q;
        imem_a2    = pc_q + 32'd4;
        buf_count  = count_q;
        out_valid0 = (count_q >= CNT_W'(1)) && !redirect_valid;
        out_valid1 = (count_q >= CNT_W'(2)) && !redirect_valid;
        out_instr0 = out_valid0 ? instr_mem[rd_ptr_q]  : 32'd0;
        out_pc0    = out_valid0 ? pc_mem[rd_ptr_q]     : 32'd0;
        out_instr1 = out_valid1 ? instr_mem[rd_ptr1_c] : 32'd0;
        out_pc1    = out_valid1 ? pc_mem[rd_ptr1_c]    : 32'd0;
    end

endmodule

// File: tb/tb_fetch_dual.sv
// Bench for fetch_dual: queue-based reference model plus directed pins,
// a second instance for PC wrap-around, and randomized redirect/ready traffic.
module tb_fetch_dual;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   imem_a1, imem_a2, imem_rd1, imem_rd2;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [1:0]    dec_ready;
    logic          out_valid0, out_valid1;
    logic [31:0]   out_instr0, out_pc0, out_instr1, out_pc1;
    logic [CW-1:0] buf_count;

    logic [31:0]   b_a1, b_a2, b_rd1, b_rd2;
    logic          b_redir = 1'b0;
    logic [31:0]   b_redir_pc = 32'd0;
    logic [1:0]    b_ready = 2'd2;
    logic          b_v0, b_v1;
    logic [31:0]   b_i0, b_p0, b_i1, b_p1;
    logic [CW-1:0] b_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Instruction memory image: word i holds 0x1000 + i
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    assign imem_rd1 = mem_word(imem_a1);
    assign imem_rd2 = mem_word(imem_a2);
    assign b_rd1    = mem_word(b_a1);
    assign b_rd2    = mem_word(b_a2);

    fetch_dual #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_a1(imem_a1), .imem_a2(imem_a2),
        .imem_rd1(imem_rd1), .imem_rd2(imem_rd2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_ready(dec_ready),
        .out_valid0(out_valid0), .out_instr0(out_instr0), .out_pc0(out_pc0),
        .out_valid1(out_valid1), .out_instr1(out_instr1), .out_pc1(out_pc1),
        .buf_count(buf_count)
    );

    fetch_dual #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_a1(b_a1), .imem_a2(b_a2),
        .imem_rd1(b_rd1), .imem_rd2(b_rd2),
        .redirect_valid(b_redir), .redirect_pc(b_redir_pc),
        .dec_ready(b_ready),
        .out_valid0(b_v0), .out_instr0(b_i0), .out_pc0(b_p0),
        .out_valid1(b_v1), .out_instr1(b_i1), .out_pc1(b_p1),
        .buf_count(b_cnt)
    );

    // Reference model: program-order queue of fetched entries plus the PC
    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];
    logic [31:0] m_pc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset(input logic [31:0] rpc);
        q_instr.delete();
        q_pc.delete();
        m_pc = {rpc[31:2], 2'b00};
    endtask

    // Advance the model across one clock edge using the current inputs
    task automatic model_step();
        int n;
        int free_slots;
        if (redirect_valid) begin
            q_instr.delete();
            q_pc.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            free_slots = int'(DEPTH) - q_pc.size();
            n = (dec_ready == 2'd3) ? 2 : int'(dec_ready);
            if (n > q_pc.size()) n = q_pc.size();
            repeat (n) begin
                void'(q_instr.pop_front());
                void'(q_pc.pop_front());
            end
            if (free_slots >= 2) begin
                q_instr.push_back(mem_word(m_pc));
                q_pc.push_back(m_pc);
                q_instr.push_back(mem_word(m_pc + 32'd4));
                q_pc.push_back(m_pc + 32'd4);
                m_pc = m_pc + 32'd8;
            end
        end
    endtask

    // Compare every DUT output against the model after inputs settle
    task automatic check_all();
        int  sz;
        bit  ev0, ev1;
        #1;
        sz  = q_pc.size();
        ev0 = (sz >= 1) && !redirect_valid && rst_n;
        ev1 = (sz >= 2) && !redirect_valid && rst_n;
        chk("valid0", 32'(out_valid0), 32'(ev0));
        chk("valid1", 32'(out_valid1), 32'(ev1));
        if (ev0) begin
            chk("instr0", out_instr0, q_instr[0]);
            chk("pc0", out_pc0, q_pc[0]);
        end else begin
            chk("instr0_zero", out_instr0, 32'd0);
            chk("pc0_zero", out_pc0, 32'd0);
        end
        if (ev1) begin
            chk("instr1", out_instr1, q_instr[1]);
            chk("pc1", out_pc1, q_pc[1]);
        end else begin
            chk("instr1_zero", out_instr1, 32'd0);
            chk("pc1_zero", out_pc1, 32'd0);
        end
        chk("imem_a1", imem_a1, m_pc);
        chk("imem_a2", imem_a2, m_pc + 32'd4);
        chk("buf_count", 32'(buf_count), 32'(sz));
    endtask

    task automatic next_cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        dec_ready      = 2'd2;
        model_reset(32'd0);

        // Reset state
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_count_lit", 32'(buf_count), 32'd0);
        rst_n = 1'b1;

        // Streaming with dec_ready = 2, plus wrap instance pins
        for (int i = 0; i < 6; i++) begin
            check_all();
            if (i == 0) begin
                chk("release_v0_lit", 32'(out_valid0), 32'd0);
                chk("wrap_a1_lit", b_a1, 32'hFFFF_FFF8);
                chk("wrap_a2_lit", b_a2, 32'hFFFF_FFFC);
            end
            if (i == 1) begin
                chk("first_pc0_lit", out_pc0, 32'h0);
                chk("first_pc1_lit", out_pc1, 32'h4);
                chk("first_instr1_lit", out_instr1, 32'h1001);
                chk("first_count_lit", 32'(buf_count), 32'd2);
                chk("wrap_pc0_lit", b_p0, 32'hFFFF_FFF8);
                chk("wrap_pc1_lit", b_p1, 32'hFFFF_FFFC);
                chk("wrap_instr0_lit", b_i0, 32'h4000_0FFE);
            end
            if (i == 2) begin
                chk("second_pc0_lit", out_pc0, 32'h8);
                chk("second_instr0_lit", out_instr0, 32'h1002);
                chk("wrap_next_pc0_lit", b_p0, 32'h0);
                chk("wrap_next_pc1_lit", b_p1, 32'h4);
            end
            next_cycle();
        end

        // Decode stalls: buffer fills to DEPTH and fetch stops
        dec_ready = 2'd0;
        for (int i = 0; i < 10; i++) begin
            check_all();
            next_cycle();
        end
        check_all();
        chk("full_count_lit", 32'(buf_count), 32'd8);

        // Drain one per cycle
        dec_ready = 2'd1;
        for (int i = 0; i < 6; i++) begin
            check_all();
            next_cycle();
        end

        // Refill, then redirect to 0x203 from a full buffer
        dec_ready = 2'd0;
        for (int i = 0; i < 4; i++) begin
            check_all();
            next_cycle();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        check_all();
        chk("redir_full_lit", 32'(buf_count), 32'd8);
        chk("redir_v0_lit", 32'(out_valid0), 32'd0);
        next_cycle();
        redirect_valid = 1'b0;
        dec_ready      = 2'd2;
        check_all();
        chk("redir_count_lit", 32'(buf_count), 32'd0);
        chk("redir_a1_lit", imem_a1, 32'h200);
        next_cycle();
        check_all();
        chk("redir_pc0_lit", out_pc0, 32'h200);
        chk("redir_pc1_lit", out_pc1, 32'h204);
        chk("redir_instr0_lit", out_instr0, 32'h1080);
        next_cycle();

        // Randomized redirects and decode readiness
        for (int i = 0; i < 400; i++) begin
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            dec_ready      = 2'($urandom_range(0, 3));
            check_all();
            next_cycle();
        end

        // Asynchronous reset between edges, mid-stream
        redirect_valid = 1'b0;
        dec_ready      = 2'd2;
        #2;
        rst_n = 1'b0;
        model_reset(32'd0);
        check_all();
        chk("async_rst_count_lit", 32'(buf_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_all();
            if (i == 1) chk("restart_pc0_lit", out_pc0, 32'h0);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
